// File: rtl/conbus_arbiter_pkg.sv
// conbus_pack: shared definitions for the conbus arbiter slice.
//   m_number                   - default number of requesting masters
//   CONBUS_ARB_TIMEOUT_DEFAULT - default watchdog limit in cycles
//   arb_state_t                - arbiter FSM states; ABORT exists only when
//                                CONBUS_ARBITER_TIMEOUT_EN is defined
package conbus_pack;

    localparam int unsigned m_number                   = 8;
    localparam int unsigned CONBUS_ARB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
`ifdef CONBUS_ARBITER_TIMEOUT_EN
        TURN  = 2'd2,
        ABORT = 2'd3
`else
        TURN  = 2'd2
`endif
    } arb_state_t;

endpackage

// File: rtl/conbus_rr_pick.sv
// conbus_rr_pick: combinational rotating-priority search.
//   eligible - candidate request vector
//   last_idx - index of the previous winner; search starts at last_idx+1
//   winner   - index of the first eligible bit found (0 when none)
//   found    - high when any eligible bit is set
module conbus_rr_pick
    import conbus_pack::*;
#(
    parameter int unsigned M_NUM = m_number
) (
    input  logic [M_NUM-1:0]         eligible,
    input  logic [$clog2(M_NUM)-1:0] last_idx,
    output logic [$clog2(M_NUM)-1:0] winner,
    output logic                     found
);

    localparam int unsigned IW = $clog2(M_NUM);

    int unsigned   pos;
    logic [IW-1:0] p;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        p      = '0;
        // Offsets 1..M_NUM visit every master once, ending on last_idx itself.
        for (int unsigned i = 1; i <= M_NUM; i++) begin
            pos = (32'(last_idx) + i) % M_NUM;
            p   = IW'(pos);
            if (!found && eligible[p]) begin
                found  = 1'b1;
                winner = p;
            end
        end
    end

endmodule

// File: rtl/conbus_arbiter.sv
// conbus_arbiter: round-robin bus arbiter for M_NUM masters.
//   clk       - system clock, rising edge
//   rst       - synchronous active-low reset
//   req       - per-master cycle request
//   ack       - slave termination (ack|err|rty) for the current cycle
//   grant     - registered one-hot grant, zero when idle
//   gnt_idx   - registered index of the granted master, 0 when idle
//   gnt_valid - registered, high whenever grant is non-zero
//   timeout   - one-cycle pulse on a watchdog abort
// Optional: define CONBUS_ARBITER_TIMEOUT_EN to build the watchdog, the
// per-master abort mask and the ABORT state; otherwise timeout is 0.
module conbus_arbiter
    import conbus_pack::*;
#(
    parameter int unsigned M_NUM       = m_number,
    parameter int unsigned TIMEOUT_CYC = CONBUS_ARB_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [M_NUM-1:0]         req,
    input  logic                     ack,
    output logic [M_NUM-1:0]         grant,
    output logic [$clog2(M_NUM)-1:0] gnt_idx,
    output logic                     gnt_valid,
    output logic                     timeout
);

    localparam int unsigned IW = $clog2(M_NUM);

    arb_state_t       state, state_n;
    logic [M_NUM-1:0] grant_n;
    logic [IW-1:0]    gnt_idx_n;
    logic             gnt_valid_n;
    logic [IW-1:0]    last_idx, last_n;
    logic [M_NUM-1:0] eligible;
    logic [IW-1:0]    winner;
    logic             found;

`ifdef CONBUS_ARBITER_TIMEOUT_EN
    logic [15:0]      cnt, cnt_n;
    logic [M_NUM-1:0] mask, mask_n;
    logic             timeout_n;

    assign eligible = req & ~mask;
`else
    logic unused_cfg;

    assign eligible   = req;
    assign timeout    = 1'b0;
    assign unused_cfg = ack | (TIMEOUT_CYC == 0);
`endif

    conbus_rr_pick #(
        .M_NUM (M_NUM)
    ) u_pick (
        .eligible (eligible),
        .last_idx (last_idx),
        .winner   (winner),
        .found    (found)
    );

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        gnt_idx_n   = gnt_idx;
        gnt_valid_n = gnt_valid;
        last_n      = last_idx;
`ifdef CONBUS_ARBITER_TIMEOUT_EN
        cnt_n       = cnt;
        timeout_n   = 1'b0;
        // A mask bit survives only while its master keeps requesting.
        mask_n      = mask & req;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n          = GRANT;
                    grant_n          = '0;
                    grant_n[winner]  = 1'b1;
                    gnt_idx_n        = winner;
                    gnt_valid_n      = 1'b1;
                    last_n           = winner;
`ifdef CONBUS_ARBITER_TIMEOUT_EN
                    cnt_n            = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    state_n     = TURN;
                    grant_n     = '0;
                    gnt_idx_n   = '0;
                    gnt_valid_n = 1'b0;
                end
`ifdef CONBUS_ARBITER_TIMEOUT_EN
                else if (cnt == 16'(TIMEOUT_CYC)) begin
                    state_n     = ABORT;
                    grant_n     = '0;
                    gnt_idx_n   = '0;
                    gnt_valid_n = 1'b0;
                    timeout_n   = 1'b1;
                end else if (ack) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
`endif
            end
            TURN: begin
                state_n = IDLE;
            end
`ifdef CONBUS_ARBITER_TIMEOUT_EN
            ABORT: begin
                // gnt_idx is already 0 here; last_idx still names the aborted owner.
                mask_n[last_idx] = 1'b1;
                state_n          = IDLE;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            last_idx  <= IW'(M_NUM - 1);
`ifdef CONBUS_ARBITER_TIMEOUT_EN
            timeout   <= 1'b0;
            cnt       <= '0;
            mask      <= '0;
`endif
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= gnt_valid_n;
            last_idx  <= last_n;
`ifdef CONBUS_ARBITER_TIMEOUT_EN
            timeout   <= timeout_n;
            cnt       <= cnt_n;
            mask      <= mask_n;
`endif
        end
    end

endmodule

// File: tb/tb_conbus_arbiter.sv
// tb_conbus_arbiter: directed and random stimulus for conbus_arbiter, checked
// cycle by cycle against a behavioural model of the arbitration rules.
// Watchdog scenarios run only when CONBUS_ARBITER_TIMEOUT_EN is defined.
module tb_conbus_arbiter;

    localparam int M = 8;
`ifdef CONBUS_ARBITER_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [M-1:0] req = '0;
    logic         ack = 1'b0;
    logic [M-1:0] grant;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    conbus_arbiter #(
        .M_NUM       (M),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: owner = granted master or -1; gap = TURN cycles still to run;
    // abort_pend = ABORT cycle still to run; mask = masters locked out.
    int           m_owner    = -1;
    int           m_gap      = 0;
    int           m_last     = M - 1;
    int           m_cnt      = 0;
    bit           m_abort    = 1'b0;
    bit           m_to       = 1'b0;
    bit [M-1:0]   m_mask     = '0;

    int seq[$];
    bit prev_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int         w;
        bit [M-1:0] el;
        bit [M-1:0] setm;
        setm = '0;
        if (!rst) begin
            m_owner = -1; m_gap = 0; m_last = M - 1; m_cnt = 0;
            m_abort = 1'b0; m_to = 1'b0; m_mask = '0;
        end else begin
            m_to = 1'b0;
            el   = req & ~m_mask;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_owner = -1;
                    m_gap   = 1;
                end else if (TO_EN && m_cnt == TO) begin
                    m_owner = -1;
                    m_abort = 1'b1;
                    m_to    = 1'b1;
                end else begin
                    m_cnt = ack ? 0 : m_cnt + 1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (m_abort) begin
                setm[m_last] = 1'b1;
                m_abort      = 1'b0;
            end else begin
                w = -1;
                for (int k = 1; k <= M; k++)
                    if (w < 0 && el[(m_last + k) % M]) w = (m_last + k) % M;
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_cnt   = 0;
                end
            end
            if (TO_EN) m_mask = (m_mask & req) | setm;
        end
    endtask

    task automatic step();
        logic [M-1:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? (M'(1) << m_owner) : '0;
        chk("grant",     32'(grant),     32'(eg));
        chk("gnt_idx",   32'(gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout",   32'(timeout),   32'(m_to));
        if (gnt_valid && !prev_v) seq.push_back(int'(gnt_idx));
        prev_v = gnt_valid;
    endtask

    task automatic do_reset();
        rst = 1'b0; ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        seq.delete();
    endtask

    // Each owner holds for `hold` granted cycles, then drops its bit once.
    task automatic run_release(input logic [M-1:0] base, input int hold, input int cycles);
        int h;
        logic [M-1:0] r;
        h = 0;
        for (int i = 0; i < cycles; i++) begin
            r = base;
            if (m_owner >= 0 && h >= hold) r[m_owner] = 1'b0;
            req = r;
            step();
            h = (m_owner >= 0) ? h + 1 : 0;
        end
    endtask

    initial begin
        int exp31[3];
        int t_at;
        exp31 = '{0, 2, 0};

        // Reset holds outputs at zero even with a request present.
        req = 8'h01;
        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        step();
        chk("first_grant", 32'(grant), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'h0);
        req = '0;
        repeat (4) step();
        chk("idle_grant", 32'(grant), 32'h0);

        // Two masters alternating.
        req = 8'h05;
        do_reset();
        run_release(8'h05, 3, 40);
        chk("alt_count_ok", 32'(seq.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) chk("alt_seq", 32'(seq[i]), 32'(exp31[i]));

        // All masters requesting: strict rotation.
        req = 8'hFF;
        do_reset();
        run_release(8'hFF, 2, 60);
        chk("rot_count_ok", 32'(seq.size() >= 9), 32'd1);
        for (int i = 0; i < 9; i++) chk("rot_seq", 32'(seq[i]), 32'(i % M));

        // Owner keeps the bus against competing requests.
        req = 8'h04;
        do_reset();
        step();
        req = 8'hFF;
        repeat (6) begin
            step();
            chk("hold_grant", 32'(grant), 32'h04);
        end
        req = 8'hFB;
        repeat (4) step();
        chk("hold_next", 32'(grant), 32'h08);

        // Reset mid-grant, then master 0 wins first.
        req = 8'h20;
        do_reset();
        repeat (3) step();
        chk("m5_grant", 32'(grant), 32'h20);
        rst = 1'b0;
        step();
        chk("mid_rst", 32'(grant), 32'h0);
        rst = 1'b1;
        req = 8'h21;
        step();
        chk("post_rst", 32'(grant), 32'h01);

`ifdef CONBUS_ARBITER_TIMEOUT_EN
        // Watchdog abort with ack held low.
        req = 8'h08;
        do_reset();
        step();
        chk("wd_grant", 32'(grant), 32'h08);
        t_at = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (timeout && t_at == 0) t_at = i;
        end
        chk("wd_at", 32'(t_at), 32'd5);
        repeat (5) begin
            step();
            chk("wd_masked", 32'(gnt_valid), 32'd0);
        end
        req = '0;
        step();
        req = 8'h08;
        step();
        chk("wd_regrant", 32'(grant), 32'h08);
        // ack at count 3 keeps the counter below the limit.
        for (int i = 0; i < 16; i++) begin
            ack = (i % 4 == 3);
            step();
            chk("wd_noabort", 32'(timeout), 32'd0);
        end
        ack = 1'b0;
`else
        t_at = 0;
`endif

        // Random traffic.
        req = '0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req = req ^ (M'($urandom) & M'($urandom) & M'($urandom));
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 59) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
